// File: rtl/conv_geom_pkg.sv
// Shared geometry helpers and FSM encoding for the convolution window scheduler.
package conv_geom_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   function automatic int out_dim(input int n, input int k, input int d, input int p, input int s);
      return (n + 2 * p - d * (k - 1) - 1) / s + 1;
   endfunction

   // Index width; a 1-entry axis still needs one bit to carry the constant 0.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int coord_w(input int n, input int p);
      return $clog2(n + p) + 1;
   endfunction

endpackage

// File: rtl/conv_axis_counter.sv
// One output axis: output index plus its signed input-window origin, kept by add/reload only.
module conv_axis_counter #(
   parameter int LIMIT   = 2,
   parameter int STRIDE  = 1,
   parameter int PADDING = 0,
   parameter int IW      = 1,
   parameter int OW      = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 step,
   output logic [IW-1:0]        idx,
   output logic signed [OW-1:0] org,
   output logic                 wrap
);

   localparam logic [IW-1:0]        IDX_LAST = IW'(LIMIT - 1);
   localparam logic signed [OW-1:0] ORG_0    = OW'(-PADDING);
   localparam logic signed [OW-1:0] ORG_STEP = OW'(STRIDE);

   assign wrap = (idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         org <= ORG_0;
      end else if (load || (step && wrap)) begin
         idx <= '0;
         org <= ORG_0;
      end else if (step) begin
         idx <= idx + 1'b1;
         org <= org + ORG_STEP;
      end
   end

endmodule

// File: rtl/conv_window_scheduler.sv
// Raster-order pixel/window-origin sequencer for one conv layer pass with PE drain wait.
// Optional feature: define SCHED_STALL_CNT_EN to add the o_stall_cnt backpressure counter.
module conv_window_scheduler
   import conv_geom_pkg::*;
#(
   parameter int IN_WIDTH   = 513,
   parameter int IN_HEIGHT  = 257,
   parameter int KERNEL_0   = 3,
   parameter int KERNEL_1   = 3,
   parameter int DILATION_0 = 2,
   parameter int DILATION_1 = 2,
   parameter int PADDING_0  = 2,
   parameter int PADDING_1  = 2,
   parameter int STRIDE_0   = 1,
   parameter int STRIDE_1   = 1,
   localparam int OUT_HEIGHT = out_dim(IN_HEIGHT, KERNEL_0, DILATION_0, PADDING_0, STRIDE_0),
   localparam int OUT_WIDTH  = out_dim(IN_WIDTH, KERNEL_1, DILATION_1, PADDING_1, STRIDE_1),
   localparam int RW         = idx_w(OUT_HEIGHT),
   localparam int CW         = idx_w(OUT_WIDTH),
   localparam int RW_IN      = coord_w(IN_HEIGHT, PADDING_0),
   localparam int CW_IN      = coord_w(IN_WIDTH, PADDING_1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    i_ready,
   input  logic                    i_pe_idle,
   output logic                    o_valid,
   output logic [RW-1:0]           o_row,
   output logic [CW-1:0]           o_col,
   output logic signed [RW_IN-1:0] o_in_row,
   output logic signed [CW_IN-1:0] o_in_col,
   output logic                    o_first,
   output logic                    o_last,
   output logic                    busy,
   output logic                    done
`ifdef SCHED_STALL_CNT_EN
   ,
   output logic [31:0]             o_stall_cnt
`endif
);

   state_t state, state_nxt;
   logic   run, hs, start_ok, col_wrap, row_wrap, last_px;

   assign run      = (state == S_RUN);
   assign hs       = run & i_ready;
   assign last_px  = col_wrap & row_wrap;
   // done is registered and lands while already in IDLE, so a start in that cycle is blocked here.
   assign start_ok = (state == S_IDLE) & start & ~done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == S_FLUSH) & i_pe_idle;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_ok) state_nxt = S_RUN;
         S_RUN:   if (hs && last_px) state_nxt = S_FLUSH;
         S_FLUSH: if (i_pe_idle) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   conv_axis_counter #(
      .LIMIT(OUT_WIDTH), .STRIDE(STRIDE_1), .PADDING(PADDING_1), .IW(CW), .OW(CW_IN)
   ) u_col (
      .clk(clk), .rst_n(rst_n), .load(start_ok), .step(hs & ~last_px),
      .idx(o_col), .org(o_in_col), .wrap(col_wrap)
   );

   conv_axis_counter #(
      .LIMIT(OUT_HEIGHT), .STRIDE(STRIDE_0), .PADDING(PADDING_0), .IW(RW), .OW(RW_IN)
   ) u_row (
      .clk(clk), .rst_n(rst_n), .load(start_ok), .step(hs & col_wrap & ~row_wrap),
      .idx(o_row), .org(o_in_row), .wrap(row_wrap)
   );

   assign o_valid = run;
   assign busy    = (state != S_IDLE);
   assign o_first = run & (o_row == '0) & (o_col == '0);
   assign o_last  = run & last_px;

`ifdef SCHED_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_stall_cnt <= '0;
      end else if (start_ok) begin
         o_stall_cnt <= '0;
      end else if (run && !i_ready && (o_stall_cnt != '1)) begin
         o_stall_cnt <= o_stall_cnt + 32'd1;
      end
   end
`endif

endmodule
